// File: rtl/ex_muldiv_seq_pkg.sv
// Shared types and constants for the iterative RV64M multiply/divide unit.
// Op codes follow the funct3 ordering of the M extension.
package ex_muldiv_seq_pkg;

    localparam int DATA_BUS_W = 64;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic logic [DATA_BUS_W-1:0] sext32(input logic [31:0] v);
        return {{(DATA_BUS_W-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/ex_muldiv_prep.sv
// Operand preparation: *W extension, magnitudes, result sign and the
// single-cycle divide-by-zero / signed-overflow results.
module ex_muldiv_prep
    import ex_muldiv_seq_pkg::*;
#(
    parameter int XLEN = DATA_BUS_W
) (
    input  logic [2:0]      md_op,
    input  logic            inst_word,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] a_mag,
    output logic [XLEN-1:0] b_mag,
    output logic            neg_res,
    output logic            fast,
    output logic [XLEN-1:0] fast_data,
    output logic            is_div,
    output logic            is_rem,
    output logic            mul_hi
);

    md_op_e          op;
    logic            signed_a, signed_b, a_neg, b_neg;
    logic            div_zero, ovf;
    logic [XLEN-1:0] a_ext, b_ext, min_val, fast_raw;

    assign op = md_op_e'(md_op);

    always_comb begin
        signed_a = (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
                   (op == MD_DIV) || (op == MD_REM);
        signed_b = (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
        is_div   = md_op[2];
        is_rem   = md_op[2] & md_op[1];
        mul_hi   = ~md_op[2] & (md_op[1:0] != 2'b00);

        if (inst_word) begin
            a_ext = signed_a ? sext32(rs1_data[31:0]) : {{(XLEN-32){1'b0}}, rs1_data[31:0]};
            b_ext = signed_b ? sext32(rs2_data[31:0]) : {{(XLEN-32){1'b0}}, rs2_data[31:0]};
        end else begin
            a_ext = rs1_data;
            b_ext = rs2_data;
        end

        a_neg = signed_a & a_ext[XLEN-1];
        b_neg = signed_b & b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;

        // Unsigned operands never report negative, so a^b also covers MULHSU/MULHU.
        neg_res = is_rem ? a_neg : (a_neg ^ b_neg);

        min_val  = inst_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = is_div && (b_ext == '0);
        ovf      = is_div && signed_b && (a_ext == min_val) && (b_ext == '1);
        fast     = div_zero | ovf;

        fast_raw = '0;
        if (div_zero)
            fast_raw = is_rem ? a_ext : '1;
        else if (ovf)
            fast_raw = is_rem ? '0 : min_val;
        fast_data = inst_word ? sext32(fast_raw[31:0]) : fast_raw;
    end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Iterative radix-2 multiply / restoring divide for the EX stage.
// One shared adder serves both: hi+mcand for multiply, {rem,q_msb}-divisor for divide.
module ex_muldiv_seq
    import ex_muldiv_seq_pkg::*;
#(
    parameter int XLEN  = DATA_BUS_W,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      md_op,
    input  logic            inst_word,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            ex_stall
);

    md_state_e        state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  acc_hi, acc_lo, opnd;
    logic             is_div_r, is_rem_r, mul_hi_r, w_r, neg_r;

    logic [XLEN-1:0]  p_a_mag, p_b_mag, p_fast_data;
    logic             p_neg, p_fast, p_is_div, p_is_rem, p_mul_hi;
    logic             accept, last;

    logic [XLEN:0]    add_a, add_b, add_s;
    logic [XLEN-1:0]  hi_nx, lo_nx;
    logic [2*XLEN-1:0] prod, prod_n;
    logic [XLEN-1:0]  mul_res, quo, rem, raw_res, final_res;

    ex_muldiv_prep #(.XLEN(XLEN)) u_prep (
        .md_op     (md_op),
        .inst_word (inst_word),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .a_mag     (p_a_mag),
        .b_mag     (p_b_mag),
        .neg_res   (p_neg),
        .fast      (p_fast),
        .fast_data (p_fast_data),
        .is_div    (p_is_div),
        .is_rem    (p_is_rem),
        .mul_hi    (p_mul_hi)
    );

    assign accept = req_valid & req_ready & ~flush;
    assign last   = (cnt == (w_r ? CNT_W'(31) : CNT_W'(XLEN-1)));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ex_stall   = 1'b1;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                ex_stall  = 1'b0;
                if (req_valid && !flush)
                    state_nx = p_fast ? ST_DONE : ST_CALC;
            end
            ST_CALC: if (last) state_nx = ST_DONE;
            ST_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (flush) state_nx = ST_IDLE;
    end

    // One iteration of the shared shift/add-sub datapath.
    always_comb begin
        add_a = is_div_r ? {acc_hi, acc_lo[XLEN-1]} : {1'b0, acc_hi};
        add_b = {1'b0, opnd};
        add_s = is_div_r ? (add_a - add_b) : (add_a + add_b);
        if (is_div_r) begin
            hi_nx = add_s[XLEN] ? add_a[XLEN-1:0] : add_s[XLEN-1:0];
            lo_nx = {acc_lo[XLEN-2:0], ~add_s[XLEN]};
        end else if (acc_lo[0]) begin
            hi_nx = add_s[XLEN:1];
            lo_nx = {add_s[0], acc_lo[XLEN-1:1]};
        end else begin
            hi_nx = {1'b0, acc_hi[XLEN-1:1]};
            lo_nx = {acc_hi[0], acc_lo[XLEN-1:1]};
        end
    end

    // Result formed from the final iteration; a 32-step multiply leaves the product 32 bits high.
    always_comb begin
        prod      = w_r ? ({hi_nx, lo_nx} >> (XLEN-32)) : {hi_nx, lo_nx};
        prod_n    = neg_r ? -prod : prod;
        mul_res   = mul_hi_r ? prod_n[2*XLEN-1:XLEN] : prod_n[XLEN-1:0];
        quo       = neg_r ? -lo_nx : lo_nx;
        rem       = neg_r ? -hi_nx : hi_nx;
        raw_res   = is_div_r ? (is_rem_r ? rem : quo) : mul_res;
        final_res = w_r ? sext32(raw_res[31:0]) : raw_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            is_div_r  <= 1'b0;
            is_rem_r  <= 1'b0;
            mul_hi_r  <= 1'b0;
            w_r       <= 1'b0;
            neg_r     <= 1'b0;
            resp_data <= '0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                cnt      <= '0;
                is_div_r <= p_is_div;
                is_rem_r <= p_is_rem;
                mul_hi_r <= p_mul_hi;
                w_r      <= inst_word;
                neg_r    <= p_neg;
                acc_hi   <= '0;
                if (p_is_div) begin
                    // Dividend pre-shifted so its MSB reaches the remainder first.
                    acc_lo <= inst_word ? (p_a_mag << (XLEN-32)) : p_a_mag;
                    opnd   <= p_b_mag;
                end else begin
                    acc_lo <= p_b_mag;
                    opnd   <= p_a_mag;
                end
                if (p_fast) resp_data <= p_fast_data;
            end
        end else if (state == ST_CALC) begin
            acc_hi <= hi_nx;
            acc_lo <= lo_nx;
            cnt    <= cnt + CNT_W'(1);
            if (last && !flush) resp_data <= final_res;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: vector table plus flush, backpressure and reset sequences.
module tb_ex_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready, inst_word;
    logic [2:0]  md_op;
    logic [63:0] rs1_data, rs2_data, resp_data;
    logic        resp_valid, resp_ready, ex_stall;

    int n_tests = 0;
    int n_fail  = 0;

    ex_muldiv_seq dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .md_op      (md_op),
        .inst_word  (inst_word),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .ex_stall   (ex_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input string name, input logic [2:0] op, input logic w,
                                    input logic [63:0] a, input logic [63:0] b,
                                    input logic [63:0] exp, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.w = w; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Drive a request at a negedge, let it be taken at the next posedge, then release.
    task automatic start_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                            input logic [63:0] b, input logic rr);
        @(negedge clk);
        chk("req_ready_before_op", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; md_op = op; inst_word = w; rs1_data = a; rs2_data = b;
        resp_ready = rr;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // k = number of posedges from the accept edge (inclusive) until resp_valid is seen.
    task automatic wait_resp(output int k);
        k = 1;
        while (!resp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        start_op(v.op, v.w, v.a, v.b, 1'b1);
        wait_resp(k);
        chk({v.name, "_lat"}, 64'(k), 64'(v.lat));
        chk({v.name, "_data"}, resp_data, v.exp);
    endtask

    initial begin
        int k, seen;
        logic [63:0] held;

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; md_op = 3'd0; inst_word = 1'b0;
        rs1_data = '0; rs2_data = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_ex_stall", {63'd0, ex_stall}, 64'd0);
        rst = 1'b0;

        add_vec("mul_7x-3",       3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        add_vec("mulhu_max",      3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        add_vec("mulhsu_-1x2",    3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        add_vec("mulh_2^62x4",    3'd1, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 65);
        add_vec("mul_wrap",       3'd0, 1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001, 65);
        add_vec("mulhu_wrap",     3'd3, 1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 64'd1, 65);
        add_vec("div_ovf",        3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        add_vec("rem_ovf",        3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
        add_vec("divu_by0",       3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        add_vec("remu_by0",       3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1);
        add_vec("div_-100/7",     3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        add_vec("rem_-100/7",     3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        add_vec("divu_100/7",     3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        add_vec("remu_100/7",     3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65);
        add_vec("div_20/-6",      3'd4, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        add_vec("rem_20/-6",      3'd6, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFA, 64'd2, 65);
        add_vec("divw_-7/2",      3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        add_vec("remw_-7/2",      3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        add_vec("divuw_fffe/1",   3'd5, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        add_vec("divuw_min/1",    3'd5, 1'b1, 64'h1234_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33);
        add_vec("remuw_trunc",    3'd7, 1'b1, 64'hDEAD_BEEF_FFFF_FFFF, 64'hAAAA_0000_0000_0010, 64'hF, 33);
        add_vec("mulw_max_x2",    3'd0, 1'b1, 64'h5555_5555_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        add_vec("divw_by0",       3'd4, 1'b1, 64'h123, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        add_vec("remw_by0",       3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1);
        add_vec("divw_ovf",       3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        add_vec("remw_ovf",       3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Flush during CALC: no response, unit free next cycle, next op correct.
        @(negedge clk);
        start_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        repeat (9) @(negedge clk);
        chk("calc_ex_stall", {63'd0, ex_stall}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_req_ready", {63'd0, req_ready}, 64'd1);
        chk("flush_ex_stall", {63'd0, ex_stall}, 64'd0);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("flush_no_resp", 64'(seen), 64'd0);
        run_vec(vecs[0]);

        // Backpressure: result held for 5 cycles; a request in the handshake cycle is not taken.
        @(negedge clk);
        start_op(3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0);
        wait_resp(k);
        chk("bp_lat", 64'(k), 64'd33);
        held = resp_data;
        chk("bp_data", held, 64'hFFFF_FFFF_FFFF_FFFD);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid_hold", {63'd0, resp_valid}, 64'd1);
            chk("bp_data_hold", resp_data, 64'hFFFF_FFFF_FFFF_FFFD);
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        req_valid = 1'b1; md_op = 3'd5; inst_word = 1'b0; rs1_data = 64'd9; rs2_data = 64'd3;
        @(negedge clk);
        chk("hs_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("hs_not_accepted", {63'd0, ex_stall}, 64'd0);
        chk("hs_data_kept", resp_data, 64'hFFFF_FFFF_FFFF_FFFD);
        req_valid = 1'b0;

        // Reset in the middle of CALC.
        start_op(3'd5, 1'b0, 64'd100, 64'd7, 1'b1);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("mrst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("mrst_resp_data", resp_data, 64'd0);
        chk("mrst_ex_stall", {63'd0, ex_stall}, 64'd0);
        rst = 1'b0;
        run_vec(vecs[12]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
